// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: frames a byte (start, 8 data LSB first, odd parity, stop),
// generates PS2_CLK open-drain and aborts when the host inhibits the clock line.
module ps2_device_tx #(
    parameter int HALF_CYCLES = 2000,
    parameter int IDLE_CYCLES = 2500
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_aborted,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic [2:0] o_dbg_state
);

    // Handshake: a byte transfers on a rising edge where tx_valid and tx_ready are both 1;
    // tx_ready is high only in IDLE and tx_valid is ignored everywhere else.

    localparam int CNT_MAX = (HALF_CYCLES > IDLE_CYCLES) ? HALF_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUS = 3'd1,
        S_BIT_HIGH = 3'd2,
        S_BIT_LOW  = 3'd3,
        S_HOLDOFF  = 3'd4,
        S_ABORT    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_bit;
    logic [3:0]       w_bit_next;
    logic [10:0]      r_frame;
    logic             w_accept;
    logic             w_clk_low;
    logic             w_dat_low;
    logic             r_clk_s1;
    logic             r_clk_s;
    logic             r_dat_s1;
    logic             r_dat_s;

    // Synchronizers idle high so a reset never looks like a busy bus.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1 <= 1'b1;
            r_clk_s  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s  <= 1'b1;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s  <= r_clk_s1;
            r_dat_s1 <= PS2_DAT;
            r_dat_s  <= r_dat_s1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_frame <= 11'h7FF;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            if (w_accept) begin
                r_frame <= {1'b1, ~^tx_data, tx_data, 1'b0};
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_bit_next = r_bit;
        w_accept   = 1'b0;
        w_clk_low  = 1'b0;
        w_dat_low  = 1'b0;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        tx_aborted = 1'b0;
        case (r_state)
            S_IDLE: begin
                tx_ready   = 1'b1;
                w_cnt_next = '0;
                if (tx_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                if (r_clk_s && r_dat_s) begin
                    if (r_cnt == IDLE_LAST) begin
                        w_cnt_next = '0;
                        w_bit_next = '0;
                        w_next     = S_BIT_HIGH;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            S_BIT_HIGH: begin
                w_dat_low = ~r_frame[r_bit];
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    // Host inhibit is only sampled here, while we are releasing the clock.
                    w_next     = r_clk_s ? S_BIT_LOW : S_ABORT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_BIT_LOW: begin
                w_clk_low = 1'b1;
                w_dat_low = ~r_frame[r_bit];
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == 4'd10) begin
                        w_next = S_HOLDOFF;
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                        w_next     = S_BIT_HIGH;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    tx_done    = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_ABORT: begin
                tx_aborted = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Drives come straight from the async-reset state, so reset releases both lines at once.
    assign PS2_CLK     = w_clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT     = w_dat_low ? 1'b0 : 1'bz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: pulled-up bus, host model capturing PS2_DAT on PS2_CLK falls,
// scoreboard of sent bytes checked against each captured frame.
module tb_ps2_device_tx;

    localparam int HALF = 8;
    localparam int IDLE = 16;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_aborted;
    logic [2:0] dbg_state;
    logic       host_clk_low;
    wire        ps2_clk;
    wire        ps2_dat;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

    ps2_device_tx #(.HALF_CYCLES(HALF), .IDLE_CYCLES(IDLE)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_aborted  (tx_aborted),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .o_dbg_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hs_cyc   = 0;
    int          done_cyc = 0;
    int          abort_cyc = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    int          rx_total = 0;
    int          rx_start = 0;
    int          fall_cyc = 0;
    logic        rx_hist [0:511];
    logic [10:0] last_frame = '0;
    logic [8:0]  exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Clock and cycle counter
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        forever begin
            @(posedge CLOCK_50);
            cyc++;
        end
    end

    // Host model: capture data on every falling clock edge the host did not cause.
    initial begin
        forever begin
            @(negedge ps2_clk);
            if (!host_clk_low) begin
                if (rx_total == rx_start) fall_cyc = cyc;
                if (rx_total < 512) rx_hist[rx_total] = ps2_dat;
                rx_total++;
            end
        end
    end

    // Monitor + scoreboard, sampled mid-cycle; cycle numbers refer to the next rising edge.
    initial begin
        logic [8:0]  e;
        logic [10:0] got;
        forever begin
            @(negedge CLOCK_50);
            if (resetn && tx_valid && tx_ready) begin
                hs_cyc   = cyc + 1;
                rx_start = rx_total;
            end
            if (tx_done) begin
                done_cnt++;
                done_cyc = cyc + 1;
                got = '0;
                for (int i = 0; i < 11; i++) begin
                    if (rx_start + i < 512 && rx_start + i < rx_total) got[i] = rx_hist[rx_start + i];
                end
                last_frame = got;
                check("frame_len", rx_total - rx_start, 11);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", got, {1'b1, e[8], e[7:0], 1'b0});
                end
            end
            if (tx_aborted) begin
                abort_cnt++;
                abort_cyc = cyc + 1;
                if (exp_q.size() != 0) e = exp_q.pop_front();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic offer(input logic [7:0] b, input logic par, input bit keep);
        bit ok;
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLOCK_50);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("offer_timeout", 0, 1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge CLOCK_50);
        exp_q.push_back({par, b});
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_evt(input string tag, input int budget);
        int d0;
        int a0;
        bit got;
        d0  = done_cnt;
        a0  = abort_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLOCK_50);
            if (done_cnt != d0 || abort_cnt != a0) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        check(tag, got, 1);
    endtask

    task automatic wait_bits(input int n, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if (rx_total - rx_start >= n) begin
                got = 1'b1;
                break;
            end
        end
        check("bits_timeout", got, 1);
    endtask

    logic [7:0] ext_b [3] = '{8'h00, 8'hFF, 8'hF0};
    logic       ext_p [3] = '{1'b1, 1'b1, 1'b1};

    initial begin
        int d0;
        int a0;
        int dat_lows;
        int lat;
        int fl;
        resetn       = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        host_clk_low = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_ready", tx_ready, 1);
        check("rst_done", tx_done, 0);
        check("rst_abort", tx_aborted, 0);
        check("rst_clk", ps2_clk, 1);
        check("rst_dat", ps2_dat, 1);
        check("rst_state", dbg_state, 0);
        @(posedge CLOCK_50);
        #1 resetn = 1'b1;
        repeat (5) @(posedge CLOCK_50);
        #1;

        // Basic frame 0x1C
        offer(8'h1C, 1'b0, 1'b0);
        check("basic_busy", tx_ready, 0);
        wait_evt("basic_evt", 400);
        check("basic_done_lat", done_cyc - hs_cyc, 200);
        check("basic_first_fall", fall_cyc - hs_cyc, IDLE + HALF);
        check("basic_frame", last_frame, 11'h438);

        // Parity and data extremes
        for (int k = 0; k < 3; k++) begin
            offer(ext_b[k], ext_p[k], 1'b0);
            wait_evt("ext_evt", 400);
            check("ext_parity", last_frame[9], ext_p[k]);
            check("ext_byte", last_frame[8:1], ext_b[k]);
        end

        // Bus busy before start
        repeat (3) @(posedge CLOCK_50);
        #1;
        offer(8'h1C, 1'b0, 1'b0);
        host_clk_low = 1'b1;
        dat_lows     = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (!ps2_dat) dat_lows++;
            @(posedge CLOCK_50);
        end
        check("busy_dat_quiet", dat_lows, 0);
        check("busy_state", dbg_state, 1);
        #1 host_clk_low = 1'b0;
        wait_evt("busy_evt", 600);
        lat = done_cyc - hs_cyc;
        fl  = fall_cyc - hs_cyc;
        check("busy_done_lat_window", (lat >= 40 + IDLE + 23 * HALF) && (lat <= 44 + IDLE + 23 * HALF), 1);
        check("busy_fall_window", (fl >= 40 + IDLE + HALF) && (fl <= 44 + IDLE + HALF), 1);

        // Inhibit during bit 4 BIT_LOW
        repeat (3) @(posedge CLOCK_50);
        #1;
        d0 = done_cnt;
        a0 = abort_cnt;
        offer(8'h1C, 1'b0, 1'b0);
        wait_bits(5, 300);
        @(posedge CLOCK_50);
        #1 host_clk_low = 1'b1;
        wait_evt("inh_evt", 300);
        check("inh_abort_cnt", abort_cnt - a0, 1);
        check("inh_abort_lat", abort_cyc - hs_cyc, IDLE + 11 * HALF + 1);
        @(negedge CLOCK_50);
        check("inh_ready", tx_ready, 1);
        check("inh_dat", ps2_dat, 1);
        check("inh_state", dbg_state, 0);
        repeat (100) @(posedge CLOCK_50);
        check("inh_no_done", done_cnt - d0, 0);
        #1 host_clk_low = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #1;
        offer(8'h1C, 1'b0, 1'b0);
        wait_evt("reoffer_evt", 400);
        check("reoffer_done", done_cnt - d0, 1);
        check("reoffer_lat", done_cyc - hs_cyc, 200);

        // Reset mid-frame (0x55: bit index 2 is a 0 on the wire)
        repeat (3) @(posedge CLOCK_50);
        #1;
        offer(8'h55, 1'b1, 1'b0);
        wait_bits(3, 300);
        #1;
        check("pre_rst_clk", ps2_clk, 0);
        check("pre_rst_dat", ps2_dat, 0);
        d0 = done_cnt;
        a0 = abort_cnt;
        resetn = 1'b0;
        #1;
        check("midrst_clk", ps2_clk, 1);
        check("midrst_dat", ps2_dat, 1);
        check("midrst_ready", tx_ready, 1);
        check("midrst_state", dbg_state, 0);
        repeat (4) @(posedge CLOCK_50);
        check("midrst_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        #1 resetn = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;

        // Back-to-back with tx_valid held high
        d0 = done_cnt;
        offer(8'h12, 1'b1, 1'b1);
        offer(8'h34, 1'b0, 1'b0);
        check("b2b_gap", hs_cyc - done_cyc, 1);
        wait_evt("b2b_evt", 400);
        check("b2b_done_cnt", done_cnt - d0, 2);
        check("b2b_q_empty", exp_q.size(), 0);
        repeat (50) @(posedge CLOCK_50);
        check("b2b_no_extra", done_cnt - d0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

Device-side PS/2 transmitter: the keyboard/mouse end of the PS/2 link, generating PS2_CLK and shifting bytes to a host-side PS/2 receiver. It is used in the DE-series demo designs and testbenches as a scan-code source that loops back into the existing host-side PS/2 communication logic. A client hands it one byte at a time with a valid/ready handshake. The block frames each byte, clocks it out open-drain, and aborts cleanly if the host inhibits the bus.

## Interface
- `HALF_CYCLES`, default 2000: CLOCK_50 cycles per PS2_CLK half-period (12.5 kHz). Minimum 4.
- `IDLE_CYCLES`, default 2500: consecutive cycles both lines must read high before a frame starts. Minimum 1.
- `CLOCK_50`, in, 1: system clock.
- `resetn`, in, 1: asynchronous, active-low reset (driven from KEY[0] at top level).
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: client offers `tx_data`.
- `tx_ready`, out, 1: block can accept a byte.
- `tx_done`, out, 1: one-cycle pulse when a frame completes.
- `tx_aborted`, out, 1: one-cycle pulse when a frame is aborted by a host inhibit.
- `PS2_CLK`, inout, 1: open-drain. The block drives it to 0 or leaves it at Z.
- `PS2_DAT`, inout, 1: open-drain. The block drives it to 0 or leaves it at Z.

## Operation
- Both lines are only ever driven to 0 or left at Z; the external pull-ups provide the 1 level. Both are read through 2-flop synchronizers (`clk_s`, `dat_s`).
- The frame is 11 bits, in this order:
  - start bit = 0;
  - `tx_data[0]` through `tx_data[7]`, LSB first;
  - odd parity bit = ~^`tx_data`;
  - stop bit = 1.
- `tx_ready` = 1 only in IDLE. A handshake (`tx_valid` & `tx_ready` at a rising edge) latches the byte and parity and moves to WAIT_BUS.
- **IDLE**: both lines released; no other action.
- **WAIT_BUS**
  - The counter increments while `clk_s` & `dat_s`; it clears whenever either line reads low.
  - When the count reaches `IDLE_CYCLES`, go to BIT_HIGH with bit index 0.
- **BIT_HIGH**
  - PS2_CLK released. PS2_DAT drives 0 if the current bit is 0, Z if it is 1.
  - Lasts `HALF_CYCLES` cycles.
  - On the last cycle, if `clk_s`=0 the host is inhibiting: go to ABORT. Otherwise go to BIT_LOW.
- **BIT_LOW**
  - PS2_CLK driven 0; data unchanged. Lasts `HALF_CYCLES` cycles.
  - Then the bit index increments. After index 10, go to HOLDOFF; otherwise go to BIT_HIGH.
- **HOLDOFF**: both lines released for `HALF_CYCLES` cycles, then pulse `tx_done` and go to IDLE.
- **ABORT**: one cycle. Both lines released, pulse `tx_aborted`, byte discarded, go to IDLE. The client re-offers the byte if it wants it sent.
- The data line changes only at the start of BIT_HIGH, i.e. while the clock is high. The host samples on the PS2_CLK falling edge.
- `tx_valid` is ignored outside IDLE. `tx_data` needs to be stable only at the handshake edge.

## Timing
- Reset (asynchronous, immediate, including mid-frame):
  - state IDLE;
  - `tx_ready`=1, `tx_done`=0, `tx_aborted`=0;
  - PS2_CLK=Z and PS2_DAT=Z in the same instant reset asserts;
  - all counters and synchronizers cleared to idle (synchronizers reset to 1).
- Latency, with the bus already idle:
  - first PS2_CLK falling edge is `IDLE_CYCLES`+`HALF_CYCLES` cycles after the handshake edge (± synchronizer settling);
  - `tx_done` is `IDLE_CYCLES` + 23·`HALF_CYCLES` cycles after the handshake edge.
- `tx_ready` drops the cycle after the handshake and returns the cycle after `tx_done` or `tx_aborted`.
- Back-to-back transfers:
  - a byte can be accepted in the cycle following `tx_done`;
  - the next frame is separated from the previous one by HOLDOFF + WAIT_BUS.
- Inhibit:
  - the check happens only at the end of BIT_HIGH, so an inhibit during BIT_LOW is detected at the following BIT_HIGH end;
  - an inhibit during the stop bit's BIT_HIGH aborts (no `tx_done`);
  - an inhibit during HOLDOFF is ignored and `tx_done` is still issued.
- Simultaneous `tx_done`/`tx_aborted` is impossible; at most one pulse per accepted byte.

## Test plan
Bench settings for all scenarios: `HALF_CYCLES`=8, `IDLE_CYCLES`=16, pull-ups on both lines, and a bench-side host model sampling PS2_DAT on PS2_CLK falling edges.
- **Basic frame.** Send `tx_data`=0x1C with the bus idle.
  - Required: the host model captures 0,0,0,1,1,1,0,0,0, parity 0, stop 1.
  - `tx_done` pulses exactly 16+23·8=200 cycles after the handshake.
- **Parity and data extremes.** Send 0x00, 0xFF and 0xF0.
  - Required parity bits: 1, 1, 1.
  - Data bits must match LSB-first; the byte reconstructed by the host model equals the byte sent.
- **Bus busy before start.** Host holds PS2_CLK low for 40 cycles after the handshake, then releases it.
  - Required: no PS2_CLK or PS2_DAT activity from the block until 16 consecutive idle cycles after the release; then a normal frame and `tx_done`.
- **Inhibit mid-frame.** Host pulls PS2_CLK low during bit 4's BIT_LOW and holds it.
  - Required: `tx_aborted` pulses at the end of the next BIT_HIGH, both lines go Z, `tx_ready`=1 and no `tx_done` follows.
  - After the release, re-offering 0x1C completes normally.
- **Reset and back-to-back.** Assert `resetn`=0 mid-frame.
  - Required: PS2_CLK and PS2_DAT are Z immediately, `tx_ready`=1 and no pulses.
  - Then send 0x12 and 0x34 with `tx_valid` held high: two complete frames, two `tx_done` pulses, no lost or repeated byte.
